// File: rtl/upsp_pkg.sv
// Shared types and constants for the upscaler write-data path.
package upsp_pkg;

    localparam int PIX_W        = 24;
    localparam int CH_W         = 8;
    localparam int PIX_PER_BEAT = 4;

    typedef logic [PIX_W-1:0]              pix_t;
    typedef logic [PIX_W*PIX_PER_BEAT-1:0] beat_t;

endpackage

// File: rtl/upsp_beat_fifo.sv
// Small circular beat buffer with a registered "can accept next cycle" flag
// and an occupancy count the serializer uses as its valid.
module upsp_beat_fifo
    import upsp_pkg::*;
#(
    parameter int WIDTH = $bits(beat_t),
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // ready looks at next-cycle occupancy, so a pop while full only reopens
    // the input one edge later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            ready <= (count_next < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/upsp_wdata_serializer.sv
// Turns 4-pixel write beats into a 1-pixel/cycle RGB stream tagged with SOF/EOL.
// Define UPSP_SER_STALL_CNT_EN to add the saturating stall_cnt output.
module upsp_wdata_serializer
    import upsp_pkg::*;
#(
    parameter int BUFFER_WIDTH = PIX_W,
    parameter int PIX_PER_BEAT = 4,
    parameter int LINE_PIXELS  = 3840,
    parameter int FRAME_LINES  = 2160,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           upsp_ac_wvalid,
    input  logic [BUFFER_WIDTH*4-1:0]      upsp_ac_wdata,
    output logic                           ac_upsp_wready,
    output logic                           out_valid,
    output logic [BUFFER_WIDTH-1:0]        out_data,
    input  logic                           out_ready,
    output logic                           out_last,
`ifdef UPSP_SER_STALL_CNT_EN
    output logic [31:0]                    stall_cnt,
`endif
    output logic                           out_sof
);

    localparam int COL_W  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int IDX_W  = $clog2(PIX_PER_BEAT);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_PIXELS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PIX_PER_BEAT - 1);

    logic [BUFFER_WIDTH*4-1:0] head;
    logic [CW-1:0]             fifo_count;
    logic [BUFFER_WIDTH-1:0]   pix_arr [PIX_PER_BEAT];
    logic [IDX_W-1:0]          pix_idx;
    logic [COL_W-1:0]          col_cnt;
    logic [LINE_W-1:0]         line_cnt;
    logic                      push;
    logic                      pop;
    logic                      fire;

    upsp_beat_fifo #(
        .WIDTH (BUFFER_WIDTH*4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (upsp_ac_wdata),
        .pop       (pop),
        .head      (head),
        .ready     (ac_upsp_wready),
        .count     (fifo_count)
    );

    assign push      = upsp_ac_wvalid & ac_upsp_wready;
    assign out_valid = (fifo_count != '0);
    assign fire      = out_valid & out_ready;
    assign pop       = fire & (pix_idx == IDX_LAST);

    // data1 sits in the MSBs and goes out first.
    always_comb begin
        for (int i = 0; i < PIX_PER_BEAT; i++) begin
            pix_arr[i] = head[BUFFER_WIDTH*(PIX_PER_BEAT-i)-1 -: BUFFER_WIDTH];
        end
    end

    assign out_data = out_valid ? pix_arr[pix_idx] : '0;
    assign out_last = out_valid & (col_cnt == COL_LAST);
    assign out_sof  = out_valid & (col_cnt == '0) & (line_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_idx  <= '0;
            col_cnt  <= '0;
            line_cnt <= '0;
        end else if (fire) begin
            pix_idx <= (pix_idx == IDX_LAST) ? '0 : pix_idx + IDX_W'(1);
            if (col_cnt == COL_LAST) begin
                col_cnt  <= '0;
                line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + LINE_W'(1);
            end else begin
                col_cnt <= col_cnt + COL_W'(1);
            end
        end
    end

`ifdef UPSP_SER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
